// File: rtl/dft_sequencer_pkg.sv
// Shared constants and state encoding for the DFT load/settle/drain sequencer.
package dft_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam logic [4:0] DFT_BASE   = 5'b11111;
  localparam int         FRAME_LEN  = 8;
  localparam int         FC_WIDTH   = 16;
  localparam logic [2:0] LAST_IDX   = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/dft_sequencer.sv
// Streams 8 samples into the DFT block, waits SETTLE cycles, then drains 8 results.
// First result is valid SETTLE+1 cycles after the 8th input; out_ready=0 freezes the drain.
module dft_sequencer
  import dft_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic                mem_write,
  output logic [WIDTH-1:0]    mem_adr,
  output logic [WIDTH-1:0]    mem_writedata,
  input  logic [WIDTH-1:0]    mem_readdata,
  output logic                busy,
  output logic [FC_WIDTH-1:0] frame_count
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              state, state_nxt;
  logic [2:0]          idx, idx_nxt;
  logic [SW-1:0]       settle_cnt, settle_nxt;
  logic [FC_WIDTH-1:0] frame_count_q, fc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      settle_cnt    <= '0;
      frame_count_q <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      settle_cnt    <= settle_nxt;
      frame_count_q <= fc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    settle_nxt    = settle_cnt;
    fc_nxt        = frame_count_q;
    in_ready      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
        end
      end
      S_LOAD: begin
        in_ready      = 1'b1;
        mem_write     = in_valid;
        mem_writedata = in_data;
        if (in_valid) begin
          idx_nxt = idx + 3'd1;
          if (idx == LAST_IDX) begin
            state_nxt  = S_SETTLE;
            settle_nxt = SW'(SETTLE - 1);
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_nxt = S_DRAIN;
        else                  settle_nxt = settle_cnt - SW'(1);
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem_readdata;
        out_last  = (idx == LAST_IDX);
        if (out_ready) begin
          idx_nxt = idx + 3'd1;
          if (idx == LAST_IDX) begin
            fc_nxt    = frame_count_q + 1'b1;
            state_nxt = enable ? S_LOAD : S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over every handshake decided above; outputs keep the current state.
    if (flush) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      fc_nxt    = frame_count_q;
    end
  end

  assign mem_adr     = WIDTH'({DFT_BASE, idx});
  assign busy        = (state != S_IDLE);
  assign frame_count = frame_count_q;

endmodule
